// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// slave is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [1:0]            req0_op;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [1:0]            req1_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [DATA_WIDTH-1:0] alu_input_1;
  logic [DATA_WIDTH-1:0] alu_input_2;
  logic [1:0]            alu_control;
  logic [DATA_WIDTH-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_result,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
    output alu_input_1, alu_input_2, alu_control
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready, alu_result,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
    input  alu_input_1, alu_input_2, alu_control
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, one op in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to req0.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q, rsp_data_q;
  logic [1:0]            op_q;
  logic                  id_q;
  logic                  any_valid, grant, handshake;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // Gated by reset so no ready is ever shown while reset is asserted.
  assign handshake = (state_q == StIdle) & any_valid & ~reset;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else                                  grant = bus.req1_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_grant_q <= 1'b1;
    else if (handshake) last_grant_q <= grant;
  end
`else
  assign grant = ~bus.req0_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (handshake) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req0_ready = handshake & ~grant;
    bus.req1_ready = handshake & grant;
    bus.rsp_valid  = (state_q == StResp);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (handshake) begin
        a_q  <= grant ? bus.req1_a  : bus.req0_a;
        b_q  <= grant ? bus.req1_b  : bus.req0_b;
        op_q <= grant ? bus.req1_op : bus.req0_op;
        id_q <= grant;
      end
      if (state_q == StExec) rsp_data_q <= bus.alu_result;
    end
  end

  assign bus.alu_input_1 = a_q;
  assign bus.alu_input_2 = b_q;
  assign bus.alu_control = op_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
endmodule
